reg_mem_arbiter: RTL and testbench

Two-requester access controller for the shared reg_mem register file (DATA_WIDTH x 2**ADDR_BITS). It accepts independent read/write requests from two clients and arbitrates round-robin. It drives the single reg_mem port (addr, data_in, wen) and returns read data to the winning client with a valid pulse. It sits between the client logic and the reg_mem instance, and is the only driver of reg_mem inputs.

---
 rtl/reg_mem_arbiter_pkg.sv | 24 ++
 rtl/reg_mem_arbiter_if.sv | 60 ++++++
 rtl/reg_mem_arbiter_rr_arb2.sv | 39 +++
 rtl/reg_mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_reg_mem_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/reg_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_mem_arb_pkg
// Description : Shared types and default sizes for the reg_mem arbiter:
//               FSM state encoding, client id type, default widths.
// Config      : ARB_FIXED_PRIO_EN (used by rr_arb2 / reg_mem_arbiter)
// Revision    : 1.0 - initial release
// ============================================================================
package reg_mem_arb_pkg;

  localparam int unsigned C_DATA_WIDTH = 4;
  localparam int unsigned C_ADDR_BITS  = 3;

  // IDLE accepts grants; RD_CAP is the second cycle of a read.
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_RD_CAP = 1'b1
  } state_t;

  // Client index: 0 or 1.
  typedef logic [0:0] client_id_t;

endpackage : reg_mem_arb_pkg
`default_nettype wire

// File: rtl/reg_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_mem_arbiter_if
// Description : Bundle of the two client request/response channels and the
//               single reg_mem port. The slave modport is the arbiter view,
//               the master modport is the client + memory view.
// Config      : ARB_FIXED_PRIO_EN (no effect on this file)
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_mem_arbiter_if
  import reg_mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = C_DATA_WIDTH,
  parameter int ADDR_BITS  = C_ADDR_BITS
);

  // client 0
  logic                  req0;
  logic                  we0;
  logic [ADDR_BITS-1:0]  addr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  gnt0;
  logic                  rvalid0;
  logic [DATA_WIDTH-1:0] rdata0;

  // client 1
  logic                  req1;
  logic                  we1;
  logic [ADDR_BITS-1:0]  addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  gnt1;
  logic                  rvalid1;
  logic [DATA_WIDTH-1:0] rdata1;

  // reg_mem port
  logic [ADDR_BITS-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_wen;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output mem_addr, mem_wdata, mem_wen,
    input  mem_rdata
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  mem_addr, mem_wdata, mem_wen,
    output mem_rdata
  );

endinterface : reg_mem_arbiter_if
`default_nettype wire

// File: rtl/reg_mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way picker. A lone request wins outright; on a tie the
//               client selected by ptr wins. Output is one-hot or zero.
// Config      : ARB_FIXED_PRIO_EN - client 0 always wins ties, ptr ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
  import reg_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  client_id_t ptr,
  output logic [1:0] gnt
);

`ifdef ARB_FIXED_PRIO_EN
  // ptr is kept on the port so both builds share one instantiation.
  logic w_unused_ptr;
  assign w_unused_ptr = ptr;

  // Fixed priority: client 0 first, client 1 only when client 0 is quiet.
  always_comb begin
    gnt    = 2'b00;
    gnt[0] = req[0];
    gnt[1] = req[1] & ~req[0];
  end
`else
  // Round-robin tie break on ptr; single requests pass straight through.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (ptr == 1'b1) ? 2'b10 : 2'b01;
    end
  end
`endif

endmodule : rr_arb2
`default_nettype wire

// File: rtl/reg_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_mem_arbiter
// Description : Two-client access controller for the single-port reg_mem.
//               Writes take one cycle, reads two (grant + capture); read data
//               returns registered with a one-cycle rvalid pulse.
// Config      : ARB_FIXED_PRIO_EN - fixed priority to client 0, no rr_ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_mem_arbiter
  import reg_mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = C_DATA_WIDTH,
  parameter int ADDR_BITS  = C_ADDR_BITS
)(
  input  logic              clk,
  input  logic              rst_n,
  reg_mem_arbiter_if.slave  bus
);

  state_t                r_state;
  state_t                w_next_state;
  client_id_t            r_rd_client;
  logic [ADDR_BITS-1:0]  r_rd_addr;
  logic [1:0]            r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;

  logic [1:0]            w_req;
  logic [1:0]            w_pick;
  logic [1:0]            w_gnt;
  logic                  w_grant_any;
  client_id_t            w_gnt_id;
  logic                  w_gnt_we;
  logic [ADDR_BITS-1:0]  w_gnt_addr;
  logic [DATA_WIDTH-1:0] w_gnt_wdata;
  client_id_t            w_ptr;

  // Requests are only considered while the memory is free.
  assign w_req = (r_state == ST_IDLE) ? {bus.req1, bus.req0} : 2'b00;

  rr_arb2 u_rr_arb2 (
    .req (w_req),
    .ptr (w_ptr),
    .gnt (w_pick)
  );

  // Grants are suppressed combinationally while reset is asserted.
  assign w_gnt       = rst_n ? w_pick : 2'b00;
  assign w_grant_any = (w_gnt != 2'b00);
  assign w_gnt_id    = w_gnt[1];
  assign w_gnt_we    = w_gnt_id ? bus.we1    : bus.we0;
  assign w_gnt_addr  = w_gnt_id ? bus.addr1  : bus.addr0;
  assign w_gnt_wdata = w_gnt_id ? bus.wdata1 : bus.wdata0;

`ifdef ARB_FIXED_PRIO_EN
  assign w_ptr = 1'b0;
`else
  client_id_t r_rr_ptr;

  // After any grant the other client gets priority on the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= 1'b0;
    end else if (w_grant_any) begin
      r_rr_ptr <= ~w_gnt_id;
    end
  end

  assign w_ptr = r_rr_ptr;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: a granted read occupies the memory for one extra cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_grant_any && !w_gnt_we) w_next_state = ST_RD_CAP;
      ST_RD_CAP: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Outputs: grants and the reg_mem port. When idle without a grant the
  // address parks on the last read address.
  always_comb begin
    bus.gnt0      = w_gnt[0];
    bus.gnt1      = w_gnt[1];
    bus.mem_addr  = r_rd_addr;
    bus.mem_wdata = '0;
    bus.mem_wen   = 1'b0;
    if ((r_state == ST_IDLE) && w_grant_any) begin
      bus.mem_addr = w_gnt_addr;
      if (w_gnt_we) begin
        bus.mem_wdata = w_gnt_wdata;
        bus.mem_wen   = 1'b1;
      end
    end
  end

  // Latch address and owner of a granted read for the capture cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_addr   <= '0;
      r_rd_client <= 1'b0;
    end else if ((r_state == ST_IDLE) && w_grant_any && !w_gnt_we) begin
      r_rd_addr   <= w_gnt_addr;
      r_rd_client <= w_gnt_id;
    end
  end

  // Capture read data at the end of RD_CAP and pulse rvalid for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 2'b00;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_rvalid <= 2'b00;
      if (r_state == ST_RD_CAP) begin
        if (r_rd_client == 1'b1) begin
          r_rvalid[1] <= 1'b1;
          r_rdata1    <= bus.mem_rdata;
        end else begin
          r_rvalid[0] <= 1'b1;
          r_rdata0    <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.rvalid0 = r_rvalid[0];
  assign bus.rvalid1 = r_rvalid[1];
  assign bus.rdata0  = r_rdata0;
  assign bus.rdata1  = r_rdata1;

endmodule : reg_mem_arbiter
`default_nettype wire

// File: tb/tb_reg_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_mem_arbiter
// Description : Directed self-checking bench for reg_mem_arbiter with a
//               behavioural reg_mem (sync write, registered read).
// Config      : ARB_FIXED_PRIO_EN changes the contention expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_mem_arbiter;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  reg_mem_arbiter_if #(.DATA_WIDTH(4), .ADDR_BITS(3)) bus ();

  reg_mem_arbiter #(.DATA_WIDTH(4), .ADDR_BITS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reg_mem model: write on wen, data_out registered from addr.
  logic [3:0] mem [0:7];
  always @(posedge clk) begin
    if (bus.mem_wen) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = 3'd0; bus.wdata0 = 4'd0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 3'd0; bus.wdata1 = 4'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 3'd0; bus.wdata0 = 4'd3;
    tick(); tick(); settle();
    n_vec++; if (bus.gnt0 !== 1'b0) begin n_err++; $display("FAIL rst_gnt0: got %b want 0", bus.gnt0); end
    n_vec++; if (bus.mem_wen !== 1'b0) begin n_err++; $display("FAIL rst_wen: got %b want 0", bus.mem_wen); end
    n_vec++; if (bus.rvalid0 !== 1'b0 || bus.rvalid1 !== 1'b0) begin n_err++; $display("FAIL rst_rvalid: got %b%b want 00", bus.rvalid1, bus.rvalid0); end
    n_vec++; if (bus.rdata0 !== 4'd0 || bus.rdata1 !== 4'd0) begin n_err++; $display("FAIL rst_rdata: got %h/%h want 0/0", bus.rdata0, bus.rdata1); end
    tick();
    rst_n = 1'b1;
    settle();
    n_vec++; if (bus.gnt0 !== 1'b1) begin n_err++; $display("FAIL rel_gnt0: got %b want 1", bus.gnt0); end
    n_vec++; if (bus.mem_wen !== 1'b1) begin n_err++; $display("FAIL rel_wen: got %b want 1", bus.mem_wen); end
    tick();
    idle_inputs();
  endtask

  task automatic test_write_sweep();
    logic [3:0] exp_d;
    for (int i = 0; i < 8; i++) begin
      exp_d = 4'(10 + i);
      bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 3'(i); bus.wdata0 = exp_d;
      settle();
      n_vec++; if (bus.gnt0 !== 1'b1 || bus.mem_wen !== 1'b1) begin n_err++; $display("FAIL wr_gnt[%0d]: got gnt0=%b wen=%b want 1/1", i, bus.gnt0, bus.mem_wen); end
      n_vec++; if (bus.mem_addr !== 3'(i) || bus.mem_wdata !== exp_d) begin n_err++; $display("FAIL wr_bus[%0d]: got %0d/%h want %0d/%h", i, bus.mem_addr, bus.mem_wdata, i, exp_d); end
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 3'(i);
      settle();
      n_vec++; if (bus.gnt1 !== 1'b1 || bus.mem_addr !== 3'(i)) begin n_err++; $display("FAIL rd_gnt[%0d]: got gnt1=%b addr=%0d want 1/%0d", i, bus.gnt1, bus.mem_addr, i); end
      if (i > 0) begin
        exp_d = 4'(10 + i - 1);
        n_vec++; if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== exp_d) begin n_err++; $display("FAIL rd_data[%0d]: got v=%b d=%h want 1/%h", i - 1, bus.rvalid1, bus.rdata1, exp_d); end
      end
      tick();
      settle();
      n_vec++; if (bus.gnt1 !== 1'b0 || bus.rvalid1 !== 1'b0) begin n_err++; $display("FAIL rd_cap[%0d]: got gnt1=%b v=%b want 0/0", i, bus.gnt1, bus.rvalid1); end
      tick();
    end
    idle_inputs();
    settle();
    n_vec++; if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== 4'd1) begin n_err++; $display("FAIL rd_data[7]: got v=%b d=%h want 1/1", bus.rvalid1, bus.rdata1); end
    tick();
  endtask

  task automatic test_contention();
    logic e0;
    logic e1;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 3'd2; bus.wdata0 = 4'd5;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 3'd3; bus.wdata1 = 4'd9;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_FIXED_PRIO_EN
      e0 = 1'b1;
`else
      e0 = (k % 2 == 0);
`endif
      e1 = ~e0;
      settle();
      n_vec++; if (bus.gnt0 !== e0 || bus.gnt1 !== e1) begin n_err++; $display("FAIL cont_gnt[%0d]: got %b%b want %b%b", k, bus.gnt1, bus.gnt0, e1, e0); end
      n_vec++; if (bus.mem_addr !== (e0 ? 3'd2 : 3'd3) || bus.mem_wen !== 1'b1) begin n_err++; $display("FAIL cont_bus[%0d]: got addr=%0d wen=%b want %0d/1", k, bus.mem_addr, bus.mem_wen, e0 ? 2 : 3); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_read_blocking();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 3'd4;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 3'd5; bus.wdata1 = 4'd2;
    settle();
    n_vec++; if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0 || bus.mem_wen !== 1'b0 || bus.mem_addr !== 3'd4) begin n_err++; $display("FAIL blk_T: got g=%b%b wen=%b addr=%0d want 01/0/4", bus.gnt1, bus.gnt0, bus.mem_wen, bus.mem_addr); end
    tick();
    bus.req0 = 1'b0;
    settle();
    n_vec++; if (bus.gnt1 !== 1'b0 || bus.mem_addr !== 3'd4) begin n_err++; $display("FAIL blk_T1: got gnt1=%b addr=%0d want 0/4", bus.gnt1, bus.mem_addr); end
    tick();
    settle();
    n_vec++; if (bus.gnt1 !== 1'b1 || bus.mem_wen !== 1'b1) begin n_err++; $display("FAIL blk_T2_gnt: got gnt1=%b wen=%b want 1/1", bus.gnt1, bus.mem_wen); end
    n_vec++; if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 4'd14) begin n_err++; $display("FAIL blk_T2_rd: got v=%b d=%h want 1/e", bus.rvalid0, bus.rdata0); end
    tick();
    idle_inputs();
  endtask

  task automatic test_hazard();
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 3'd6; bus.wdata0 = 4'd7;
    settle();
    n_vec++; if (bus.gnt0 !== 1'b1) begin n_err++; $display("FAIL haz_wr: got gnt0=%b want 1", bus.gnt0); end
    tick();
    idle_inputs();
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 3'd6;
    settle();
    n_vec++; if (bus.gnt1 !== 1'b1) begin n_err++; $display("FAIL haz_rd: got gnt1=%b want 1", bus.gnt1); end
    tick();
    idle_inputs();
    settle();
    n_vec++; if (bus.rvalid1 !== 1'b0) begin n_err++; $display("FAIL haz_early: got rvalid1=%b want 0", bus.rvalid1); end
    tick();
    settle();
    n_vec++; if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== 4'd7) begin n_err++; $display("FAIL haz_data: got v=%b d=%h want 1/7", bus.rvalid1, bus.rdata1); end
    tick();
  endtask

  task automatic test_withdraw();
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 3'd2;
    settle();
    n_vec++; if (bus.gnt1 !== 1'b1) begin n_err++; $display("FAIL wd_rd: got gnt1=%b want 1", bus.gnt1); end
    tick();
    idle_inputs();
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 3'd5; bus.wdata0 = 4'd4;
    settle();
    n_vec++; if (bus.gnt0 !== 1'b0) begin n_err++; $display("FAIL wd_wait: got gnt0=%b want 0", bus.gnt0); end
    tick();
    bus.req0 = 1'b0;
    settle();
    n_vec++; if (bus.gnt0 !== 1'b0 || bus.mem_wen !== 1'b0) begin n_err++; $display("FAIL wd_gone: got gnt0=%b wen=%b want 0/0", bus.gnt0, bus.mem_wen); end
    n_vec++; if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== 4'd5) begin n_err++; $display("FAIL wd_data: got v=%b d=%h want 1/5", bus.rvalid1, bus.rdata1); end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_read();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 3'd3;
    settle();
    n_vec++; if (bus.gnt0 !== 1'b1) begin n_err++; $display("FAIL mrst_gnt: got gnt0=%b want 1", bus.gnt0); end
    tick();
    idle_inputs();
    rst_n = 1'b0;
    settle();
    n_vec++; if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0 || bus.rvalid0 !== 1'b0) begin n_err++; $display("FAIL mrst_in: got g=%b%b v=%b want 00/0", bus.gnt1, bus.gnt0, bus.rvalid0); end
    tick();
    rst_n = 1'b1;
    settle();
    n_vec++; if (bus.rvalid0 !== 1'b0 || bus.rdata0 !== 4'd0) begin n_err++; $display("FAIL mrst_clr: got v=%b d=%h want 0/0", bus.rvalid0, bus.rdata0); end
    tick();
    settle();
    n_vec++; if (bus.rvalid0 !== 1'b0) begin n_err++; $display("FAIL mrst_late: got rvalid0=%b want 0", bus.rvalid0); end
    tick();
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 3'd7; bus.wdata0 = 4'd1;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 3'd0; bus.wdata1 = 4'd2;
    settle();
    n_vec++; if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin n_err++; $display("FAIL mrst_prio: got g=%b%b want 01", bus.gnt1, bus.gnt0); end
    tick();
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    bus.mem_rdata = 4'd0;
    test_reset();
    test_write_sweep();
    test_contention();
    test_read_blocking();
    test_hazard();
    test_withdraw();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_reg_mem_arbiter
`default_nettype wire
